convert_bw_stream: RTL and testbench

//  Parametrised streaming RGB->grayscale converter; next generation of ConvertBW.

---
 rtl/convert_bw_stream.sv | 138 +++++++++++++
 tb/tb_convert_bw_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/convert_bw_stream.sv
// Streaming RGB->grayscale converter: multi-lane pixels, runtime-selectable weights,
// two-stage valid/ready pipeline with SOF/EOF tags and a delivered-frame counter.
module convert_bw_stream #(
    parameter int CH_W   = 8,
    parameter int LANES  = 1,
    parameter int FCNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*3*CH_W-1:0]   in_rgb,
    input  logic                      in_sof,
    input  logic                      in_eof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*CH_W-1:0]     out_gray,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic [FCNT_W-1:0]         frame_cnt
);

    localparam int PROD_W = CH_W + 9;

    logic                    v1_reg;
    logic                    v2_reg;
    logic                    en1;
    logic                    en2;
    logic                    accept;
    logic [1:0]              cur_mode_reg;
    logic [1:0]              eff_mode;
    logic [8:0]              w_r;
    logic [8:0]              w_g;
    logic [8:0]              w_b;
    logic [LANES*PROD_W-1:0] prod_r_next;
    logic [LANES*PROD_W-1:0] prod_g_next;
    logic [LANES*PROD_W-1:0] prod_b_next;
    logic [LANES*PROD_W-1:0] prod_r_reg;
    logic [LANES*PROD_W-1:0] prod_g_reg;
    logic [LANES*PROD_W-1:0] prod_b_reg;
    logic                    sof1_reg;
    logic                    eof1_reg;
    logic [LANES*CH_W-1:0]   gray_next;

    assign en2       = ~v2_reg | out_ready;
    assign en1       = ~v1_reg | en2;
    assign in_ready  = en1;
    assign accept    = in_valid & en1;
    assign out_valid = v2_reg;

    // An SOF beat uses the mode presented with it, so the new weights apply to that beat too.
    assign eff_mode = in_sof ? mode : cur_mode_reg;

    always_comb begin
        w_r = 9'd77;
        w_g = 9'd150;
        w_b = 9'd29;
        case (eff_mode)
            2'b00: begin w_r = 9'd77; w_g = 9'd150; w_b = 9'd29; end
            2'b01: begin w_r = 9'd54; w_g = 9'd183; w_b = 9'd19; end
            2'b10: begin w_r = 9'd85; w_g = 9'd85;  w_b = 9'd86; end
            default: begin w_r = 9'd0; w_g = 9'd256; w_b = 9'd0; end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [CH_W-1:0]   r;
            logic [CH_W-1:0]   g;
            logic [CH_W-1:0]   b;
            logic [PROD_W-1:0] sum;

            assign r = in_rgb[gi*3*CH_W + 2*CH_W +: CH_W];
            assign g = in_rgb[gi*3*CH_W + CH_W +: CH_W];
            assign b = in_rgb[gi*3*CH_W +: CH_W];

            assign prod_r_next[gi*PROD_W +: PROD_W] = PROD_W'(w_r) * PROD_W'(r);
            assign prod_g_next[gi*PROD_W +: PROD_W] = PROD_W'(w_g) * PROD_W'(g);
            assign prod_b_next[gi*PROD_W +: PROD_W] = PROD_W'(w_b) * PROD_W'(b);

            // Weights sum to 256, so the rounded sum never exceeds CH_W bits after the shift.
            assign sum = prod_r_reg[gi*PROD_W +: PROD_W] + prod_g_reg[gi*PROD_W +: PROD_W]
                       + prod_b_reg[gi*PROD_W +: PROD_W] + PROD_W'(128);
            assign gray_next[gi*CH_W +: CH_W] = CH_W'(sum >> 8);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg       <= 1'b0;
            prod_r_reg   <= '0;
            prod_g_reg   <= '0;
            prod_b_reg   <= '0;
            sof1_reg     <= 1'b0;
            eof1_reg     <= 1'b0;
            cur_mode_reg <= 2'b00;
        end else begin
            if (en1) begin
                v1_reg <= in_valid;
            end
            if (accept) begin
                prod_r_reg <= prod_r_next;
                prod_g_reg <= prod_g_next;
                prod_b_reg <= prod_b_next;
                sof1_reg   <= in_sof;
                eof1_reg   <= in_eof;
                if (in_sof) begin
                    cur_mode_reg <= mode;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            out_gray  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (en2) begin
                v2_reg <= v1_reg;
                if (v1_reg) begin
                    out_gray <= gray_next;
                    out_sof  <= sof1_reg;
                    out_eof  <= eof1_reg;
                end
            end
            if (v2_reg & out_ready & out_eof) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_convert_bw_stream.sv
// Directed bench for convert_bw_stream (2 lanes, 4-bit frame counter) with a
// scoreboard fed at input acceptance and drained at output handshakes.
module tb_convert_bw_stream;

    localparam int CH_W   = 8;
    localparam int LANES  = 2;
    localparam int FCNT_W = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [1:0]              mode;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*3*CH_W-1:0] in_rgb;
    logic                    in_sof;
    logic                    in_eof;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*CH_W-1:0]   out_gray;
    logic                    out_sof;
    logic                    out_eof;
    logic [FCNT_W-1:0]       frame_cnt;

    convert_bw_stream #(.CH_W(CH_W), .LANES(LANES), .FCNT_W(FCNT_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_rgb(in_rgb), .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid),
        .out_ready(out_ready), .out_gray(out_gray), .out_sof(out_sof), .out_eof(out_eof),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*CH_W-1:0] gray;
        logic                  sof;
        logic                  eof;
    } exp_t;

    exp_t              sb[$];
    int                errors = 0;
    int                checks = 0;
    logic [1:0]        tb_mode;
    logic [FCNT_W-1:0] tb_fcnt;
    logic              hold = 1'b0;
    exp_t              held;

    function automatic logic [CH_W-1:0] gray_of(input logic [3*CH_W-1:0] p, input logic [1:0] m);
        int wr, wg, wb, r, g, b;
        case (m)
            2'b00:   begin wr = 77; wg = 150; wb = 29; end
            2'b01:   begin wr = 54; wg = 183; wb = 19; end
            2'b10:   begin wr = 85; wg = 85;  wb = 86; end
            default: begin wr = 0;  wg = 256; wb = 0;  end
        endcase
        r = int'(p[3*CH_W-1 -: CH_W]);
        g = int'(p[2*CH_W-1 -: CH_W]);
        b = int'(p[CH_W-1:0]);
        return CH_W'((wr * r + wg * g + wb * b + 128) >> 8);
    endfunction

    function automatic logic [3*CH_W-1:0] px(input int r, input int g, input int b);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            tb_mode = 2'b00;
            tb_fcnt = '0;
            hold    = 1'b0;
        end else begin
            if (hold) begin
                checks++;
                assert (out_valid === 1'b1 && {out_gray, out_sof, out_eof} === held)
                else begin
                    errors++;
                    $error("FAIL stall_hold observed=%b/%h/%b/%b expected=1/%h/%b/%b",
                           out_valid, out_gray, out_sof, out_eof, held.gray, held.sof, held.eof);
                end
            end
            hold = out_valid && !out_ready;
            held = {out_gray, out_sof, out_eof};
            if (out_valid && out_ready) begin
                $display("out gray=%h sof=%b eof=%b frame_cnt=%0d", out_gray, out_sof, out_eof, frame_cnt);
                checks++;
                assert (sb.size() > 0)
                else begin
                    errors++;
                    $error("FAIL spurious_out observed=%h expected=none", out_gray);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert ({out_gray, out_sof, out_eof} === e)
                    else begin
                        errors++;
                        $error("FAIL sb_beat observed=%h/%b/%b expected=%h/%b/%b",
                               out_gray, out_sof, out_eof, e.gray, e.sof, e.eof);
                    end
                end
                checks++;
                assert (frame_cnt === tb_fcnt)
                else begin
                    errors++;
                    $error("FAIL sb_frame_cnt observed=%0d expected=%0d", frame_cnt, tb_fcnt);
                end
                if (out_eof) tb_fcnt = tb_fcnt + 1'b1;
            end
            if (in_valid && in_ready) begin
                if (in_sof) tb_mode = mode;
                for (int k = 0; k < LANES; k++)
                    e.gray[k*CH_W +: CH_W] = gray_of(in_rgb[k*3*CH_W +: 3*CH_W], tb_mode);
                e.sof = in_sof;
                e.eof = in_eof;
                sb.push_back(e);
                $display("in  rgb=%h sof=%b eof=%b mode=%0d", in_rgb, in_sof, in_eof, tb_mode);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [LANES*3*CH_W-1:0] rgb, input logic sof,
                             input logic eof, input logic [1:0] m);
        int n = 0;
        in_valid = 1'b1;
        in_rgb   = rgb;
        in_sof   = sof;
        in_eof   = eof;
        mode     = m;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_lane0"}, out_gray[7:0], e0);
        chk({tag, "_lane1"}, out_gray[15:8], e1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", (sb.size() == 0 && !out_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  idx;
        logic acc;
        rst = 1'b1; in_valid = 1'b0; in_rgb = '0; in_sof = 1'b0; in_eof = 1'b0;
        mode = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_gray", out_gray, 0);
        chk("rst_tags", {out_sof, out_eof}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mode 00, latency and basic values
        send_beat({px(255, 0, 0), px(255, 0, 0)}, 1'b1, 1'b0, 2'b00);
        chk("lat_s1_only", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_out_valid", out_valid, 1);
        chk("t1_red", out_gray[7:0], 77);
        send_beat({px(255, 255, 255), px(255, 255, 255)}, 1'b0, 1'b0, 2'b00);
        wait_out("t1_white", 255, 255);
        send_beat({px(0, 0, 0), px(0, 0, 0)}, 1'b0, 1'b1, 2'b00);
        wait_out("t1_black", 0, 0);

        // Two lanes, each weight set
        send_beat({px(30, 60, 90), px(0, 255, 0)}, 1'b1, 1'b1, 2'b01);
        wait_out("t2_bt709", 182, 56);
        send_beat({px(30, 60, 90), px(30, 60, 90)}, 1'b1, 1'b1, 2'b10);
        wait_out("t2_avg", 60, 60);
        send_beat({px(12, 200, 7), px(12, 200, 7)}, 1'b1, 1'b1, 2'b11);
        wait_out("t2_gpass", 200, 200);

        // Mid-frame mode change is ignored until the next SOF
        send_beat({px(100, 50, 200), px(100, 50, 200)}, 1'b1, 1'b0, 2'b00);
        wait_out("t4_sof601", 82, 82);
        send_beat({px(100, 50, 200), px(100, 50, 200)}, 1'b0, 1'b1, 2'b01);
        wait_out("t4_midframe", 82, 82);
        send_beat({px(100, 50, 200), px(100, 50, 200)}, 1'b1, 1'b1, 2'b01);
        wait_out("t4_sof709", 72, 72);

        // Backpressure stream of 8 beats
        drain();
        idx = 0;
        for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
            in_valid  = 1'b1;
            in_rgb    = {px(idx * 30, 255 - idx * 20, idx * 7), px(255 - idx * 30, idx * 20, 3 + idx)};
            in_sof    = (idx == 0);
            in_eof    = (idx == 7);
            mode      = 2'b00;
            out_ready = (cyc >= 5);
            @(negedge clk);
            if (cyc == 4) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_buffered", idx, 2);
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        chk("bp_all_sent", idx, 8);
        drain();

        // Async reset with two beats in flight
        out_ready = 1'b0;
        send_beat({px(1, 2, 3), px(4, 5, 6)}, 1'b1, 1'b0, 2'b10);
        send_beat({px(7, 8, 9), px(10, 11, 12)}, 1'b0, 1'b1, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_frame_cnt", frame_cnt, 0);
        chk("arst_out_gray", out_gray, 0);
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Frame counting and wrap
        send_beat({px(30, 60, 90), px(30, 60, 90)}, 1'b1, 1'b0, 2'b01);
        wait_out("t6_post_rst", 56, 56);
        send_beat({px(30, 60, 90), px(30, 60, 90)}, 1'b0, 1'b1, 2'b00);
        send_beat({px(9, 99, 199), px(200, 100, 0)}, 1'b1, 1'b0, 2'b10);
        send_beat({px(50, 60, 70), px(80, 90, 100)}, 1'b0, 1'b0, 2'b00);
        send_beat({px(255, 1, 128), px(0, 0, 255)}, 1'b0, 1'b1, 2'b00);
        send_beat({px(12, 200, 7), px(40, 41, 42)}, 1'b1, 1'b1, 2'b11);
        drain();
        chk("t5_three_frames", frame_cnt, 3);
        for (int f = 0; f < 12; f++)
            send_beat({px(f, 2 * f, 3 * f), px(255 - f, f, 9)}, 1'b1, 1'b1, 2'(f));
        drain();
        chk("t5_frame_cnt_15", frame_cnt, 15);
        send_beat({px(1, 1, 1), px(2, 2, 2)}, 1'b1, 1'b1, 2'b00);
        drain();
        chk("t5_wrap_zero", frame_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
